dsm_quant_ef: RTL and testbench
===============================

// Module: dsm_quant_ef
// PURPOSE
//   Quantizer and error-feedback summing node of the delta-sigma modulator.
//   Adds the 16-bit input sample to the loop-filter output, saturates the sum,
//   and truncates it to OUT_BITS MSBs. Returns the quantization error to the
//   loop filter for the next sample.
//   Supervises loop stability. On a run of saturated samples it flushes
//   the loop and asks the filter to clear.
// PARAMETERS
//   OUT_BITS      4   quantizer output width, legal range 1..15; S = 16-OUT_BITS
//   OVL_LIMIT     8   consecutive saturated samples that trigger FLUSH, >=1
//   FLUSH_CYCLES  4   enabled samples spent in FLUSH, >=1
// PORTS
//   CLK        in   1         clock, rising edge
//   reset      in   1         synchronous, active-high
//   en         in   1         sample strobe; one sample is accepted per cycle with en=1
//   x_in       in   16        signed input sample
//   h1_in      in   16        signed loop-filter output for this sample
//   q_out      out  OUT_BITS  signed quantized code
//   q_valid    out  1         1-cycle pulse: q_out/e_out updated
//   e_out      out  16        signed quantization error, feeds loop-filter input
//   flush_req  out  1         high while in FLUSH; filter must clear its state
//   ovl_flag   out  1         sticky: at least one FLUSH has occurred since reset
//   ovl_count  out  16        count of saturated samples, saturates at 0xFFFF
// BEHAVIOUR
//   Reset
//     - All outputs are 0, state is RUN, and the saturation-run and flush counters are 0.
//     - reset has priority over en.
//   Arithmetic (combinational on inputs; result registered on the en cycle)
//     - v = sext18(x_in) + sext18(h1_in).
//     - vs = clamp(v, -32768, 32767); sat = (v != vs).
//     - q = vs[15:S], a floor truncation in two's complement.
//     - e = (q <<< S) - vs. Range is [-(2^S-1), 0].
//   Latency and handshake
//     - q_out, e_out and q_valid change on the edge that samples en=1, giving 1-cycle latency.
//     - With en=0, q_out/e_out/flush_req hold their values and q_valid=0.
//     - There is no backpressure. Every en is consumed.
//   FSM states: RUN, FLUSH
//     - RUN, on en:
//       - Outputs are q and e.
//       - If sat, then ovl_count++ (saturating) and sat_run++. Otherwise sat_run=0.
//       - When sat_run reaches OVL_LIMIT on this sample: go to FLUSH, set ovl_flag=1,
//         set flush_cnt=0, and set flush_req=1 on the same edge.
//       - The triggering sample's q/e are still output normally.
//     - FLUSH, on en:
//       - q_out=0, e_out=0, q_valid pulses, and inputs are ignored.
//       - ovl_count is not incremented. flush_cnt++.
//       - On the FLUSH_CYCLES-th en: go to RUN, set flush_req=0, set sat_run=0.
//   Boundaries
//     - A non-saturated sample at sat_run=OVL_LIMIT-1 resets the run, so no flush occurs.
//     - Exactly ±32768/32767 sums are not saturation.
//     - When ovl_count reaches 0xFFFF it holds there.
//     - Reset mid-FLUSH returns to RUN with all outputs 0, including ovl_flag.
//     - en=0 cycles never advance any counter.
// TESTING (OUT_BITS=4, S=12, OVL_LIMIT=8, FLUSH_CYCLES=4)
//   1. x=0x1234, h1=0x0100, en=1 -> next cycle: q_out=0x1, e_out=0xFCCC, q_valid=1 for 1 cycle.
//   2. x=0xF000, h1=0xFF00 -> q_out=0xE (-2), e_out=0xF100 (-3840), ovl_count unchanged.
//   3. x=0x7000, h1=0x7000 -> vs=0x7FFF, q_out=0x7, e_out=0xF001, ovl_count=1;
//      x=0x8000, h1=0x8000 -> q_out=0x8, e_out=0x0000.
//   4. 8 consecutive saturated samples -> flush_req=1 and ovl_flag=1 after the 8th;
//      next 4 en give q_out=0 and e_out=0; flush_req=0 after the 4th;
//      7 saturated + 1 clean sample -> no flush.
//   5. en held low 10 cycles mid-stream -> outputs hold, q_valid=0, counters frozen;
//      then reset asserted during FLUSH -> all outputs 0, state RUN next cycle.

Source files
------------

// File: rtl/dsm_quant_ef_if.sv
// Sample/result bundle between the delta-sigma loop filter and the quantizer node.
// The master drives samples and reads results. The slave is the quantizer.
interface dsm_quant_ef_if #(
  parameter int OUT_BITS = 4
);
  logic                en;
  logic [15:0]         x_in;
  logic [15:0]         h1_in;
  logic [OUT_BITS-1:0] q_out;
  logic                q_valid;
  logic [15:0]         e_out;
  logic                flush_req;
  logic                ovl_flag;
  logic [15:0]         ovl_count;

  modport master (
    output en, x_in, h1_in,
    input  q_out, q_valid, e_out, flush_req, ovl_flag, ovl_count
  );

  modport slave (
    input  en, x_in, h1_in,
    output q_out, q_valid, e_out, flush_req, ovl_flag, ovl_count
  );
endinterface

// File: rtl/dsm_quant_ef.sv
// Delta-sigma quantizer with error feedback: it saturates the sum and truncates it to OUT_BITS MSBs.
// A run of saturated samples flushes the loop for FLUSH_CYCLES samples.
module dsm_quant_ef #(
  parameter int OUT_BITS     = 4,
  parameter int OVL_LIMIT    = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic            CLK,
  input  logic            reset,
  dsm_quant_ef_if.slave   bus
);
  localparam int S  = 16 - OUT_BITS;
  localparam int RW = $clog2(OVL_LIMIT + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [RW-1:0] RUN_LIMIT = RW'(OVL_LIMIT);
  localparam logic [FW-1:0] FLUSH_LEN = FW'(FLUSH_CYCLES);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t               state;
  logic [RW-1:0]        sat_run;
  logic [FW-1:0]        flush_cnt;

  logic signed [17:0]   v;
  logic [15:0]          vs;
  logic                 sat;
  logic [OUT_BITS-1:0]  q;
  logic [15:0]          e;

  always_comb begin
    v   = {{2{bus.x_in[15]}}, bus.x_in} + {{2{bus.h1_in[15]}}, bus.h1_in};
    vs  = v[15:0];
    sat = 1'b0;
    if (v > 18'sd32767) begin
      vs  = 16'h7FFF;
      sat = 1'b1;
    end else if (v < -18'sd32768) begin
      vs  = 16'h8000;
      sat = 1'b1;
    end
    q = vs[15:S];
    // Floor truncation makes the error non-positive: the code, re-expanded, minus the clamped sum.
    e = {q, {S{1'b0}}} - vs;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= RUN;
      sat_run       <= '0;
      flush_cnt     <= '0;
      bus.q_out     <= '0;
      bus.q_valid   <= 1'b0;
      bus.e_out     <= '0;
      bus.flush_req <= 1'b0;
      bus.ovl_flag  <= 1'b0;
      bus.ovl_count <= '0;
    end else begin
      bus.q_valid <= bus.en;
      if (bus.en) begin
        case (state)
          RUN: begin
            bus.q_out <= q;
            bus.e_out <= e;
            if (sat) begin
              if (bus.ovl_count != '1)
                bus.ovl_count <= bus.ovl_count + 16'd1;
              sat_run <= sat_run + 1'b1;
              if (sat_run + 1'b1 == RUN_LIMIT) begin
                state         <= FLUSH;
                flush_cnt     <= '0;
                bus.flush_req <= 1'b1;
                bus.ovl_flag  <= 1'b1;
              end
            end else begin
              sat_run <= '0;
            end
          end
          FLUSH: begin
            bus.q_out <= '0;
            bus.e_out <= '0;
            if (flush_cnt + 1'b1 == FLUSH_LEN) begin
              state         <= RUN;
              flush_cnt     <= '0;
              sat_run       <= '0;
              bus.flush_req <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dsm_quant_ef.sv
// Directed bench for dsm_quant_ef with OUT_BITS=4, OVL_LIMIT=8, FLUSH_CYCLES=4.
// Expected values are hand-computed.
module tb_dsm_quant_ef;
  logic CLK = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  dsm_quant_ef_if #(.OUT_BITS(4)) bus ();

  dsm_quant_ef #(
    .OUT_BITS    (4),
    .OVL_LIMIT   (8),
    .FLUSH_CYCLES(4)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic [15:0] x, input logic [15:0] h1);
    bus.en    = en;
    bus.x_in  = x;
    bus.h1_in = h1;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] q, input logic [15:0] e,
                         input logic qv, input logic fr, input logic of, input logic [15:0] oc);
    chk({tag, ".q_out"},     32'(bus.q_out),     32'(q));
    chk({tag, ".e_out"},     32'(bus.e_out),     32'(e));
    chk({tag, ".q_valid"},   32'(bus.q_valid),   32'(qv));
    chk({tag, ".flush_req"}, 32'(bus.flush_req), 32'(fr));
    chk({tag, ".ovl_flag"},  32'(bus.ovl_flag),  32'(of));
    chk({tag, ".ovl_count"}, 32'(bus.ovl_count), 32'(oc));
  endtask

  initial begin
    // Reset with en=1 and saturating inputs: reset must win.
    reset = 1'b1;
    step(1'b1, 16'h7000, 16'h7000);
    step(1'b1, 16'h7000, 16'h7000);
    chk_all("reset", 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;

    // Test 1: normal sample, then the q_valid pulse ends.
    step(1'b1, 16'h1234, 16'h0100);
    chk_all("t1", 4'h1, 16'hFCCC, 1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b0, 16'h0000, 16'h0000);
    chk_all("t1_hold", 4'h1, 16'hFCCC, 1'b0, 1'b0, 1'b0, 16'd0);

    // Test 2: negative sum, no saturation.
    step(1'b1, 16'hF000, 16'hFF00);
    chk_all("t2", 4'hE, 16'hF100, 1'b1, 1'b0, 1'b0, 16'd0);

    // Test 3: positive and negative saturation.
    step(1'b1, 16'h7000, 16'h7000);
    chk_all("t3_pos", 4'h7, 16'hF001, 1'b1, 1'b0, 1'b0, 16'd1);
    step(1'b1, 16'h8000, 16'h8000);
    chk_all("t3_neg", 4'h8, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd2);

    // Exact limits are not saturation.
    step(1'b1, 16'h4000, 16'h3FFF);
    chk_all("edge_max", 4'h7, 16'hF001, 1'b1, 1'b0, 1'b0, 16'd2);
    step(1'b1, 16'hC000, 16'hC000);
    chk_all("edge_min", 4'h8, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd2);

    // Test 4: eight saturated samples trigger a flush.
    for (int i = 0; i < 7; i++) step(1'b1, 16'h7000, 16'h7000);
    chk_all("t4_sat7", 4'h7, 16'hF001, 1'b1, 1'b0, 1'b0, 16'd9);
    step(1'b1, 16'h7000, 16'h7000);
    chk_all("t4_sat8", 4'h7, 16'hF001, 1'b1, 1'b1, 1'b1, 16'd10);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h7000, 16'h7000);
    chk_all("t4_flush3", 4'h0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'd10);
    step(1'b1, 16'h7000, 16'h7000);
    chk_all("t4_flush4", 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'd10);

    // A clean sample after seven saturated ones clears the run.
    for (int i = 0; i < 7; i++) step(1'b1, 16'h8000, 16'h8000);
    step(1'b1, 16'h1234, 16'h0100);
    chk_all("t4_clean", 4'h1, 16'hFCCC, 1'b1, 1'b0, 1'b1, 16'd17);
    step(1'b1, 16'h7000, 16'h7000);
    chk_all("t4_norun", 4'h7, 16'hF001, 1'b1, 1'b0, 1'b1, 16'd18);

    // Test 5: en low for 10 cycles. Outputs hold and counters stay frozen.
    for (int i = 0; i < 10; i++) step(1'b0, 16'h7000, 16'h7000);
    chk_all("t5_idle", 4'h7, 16'hF001, 1'b0, 1'b0, 1'b1, 16'd18);
    // The run is at 1. Seven more saturated samples flush the loop.
    for (int i = 0; i < 6; i++) step(1'b1, 16'h8000, 16'h8000);
    chk_all("t5_run7", 4'h8, 16'h0000, 1'b1, 1'b0, 1'b1, 16'd24);
    step(1'b1, 16'h8000, 16'h8000);
    chk_all("t5_flush", 4'h8, 16'h0000, 1'b1, 1'b1, 1'b1, 16'd25);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h1234, 16'h0100);
    chk_all("t5_flush_idle", 4'h8, 16'h0000, 1'b0, 1'b1, 1'b1, 16'd25);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1234, 16'h0100);
    chk_all("t5_flush3", 4'h0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'd25);

    // Reset during FLUSH.
    reset = 1'b1;
    step(1'b1, 16'h7000, 16'h7000);
    chk_all("t5_reset", 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    step(1'b1, 16'hF000, 16'hFF00);
    chk_all("t5_run", 4'hE, 16'hF100, 1'b1, 1'b0, 1'b0, 16'd0);
    // A fresh run needs a full eight saturated samples.
    for (int i = 0; i < 7; i++) step(1'b1, 16'h7000, 16'h7000);
    chk_all("t5_rerun7", 4'h7, 16'hF001, 1'b1, 1'b0, 1'b0, 16'd7);
    step(1'b1, 16'h7000, 16'h7000);
    chk_all("t5_rerun8", 4'h7, 16'hF001, 1'b1, 1'b1, 1'b1, 16'd8);

    step(1'b0, 16'h0000, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
